// File: rtl/bpm_test_link_pkg.sv
// Definitions shared by the BPM test-pattern writer and the test-link checker.
package bpm_test_link_pkg;

    localparam logic [15:0] MAGIC_HDR = 16'hA5BE;
    localparam logic [15:0] MAGIC_X   = 16'hCAFE;
    localparam logic [15:0] MAGIC_Y   = 16'hBEEF;

    localparam int unsigned IDX_W         = 5;
    localparam int unsigned HDR_MAGIC_LSB = 16;
    localparam int unsigned HDR_MARK_BIT  = 15;
    localparam int unsigned HDR_CELL_LSB  = 10;
    localparam int unsigned HDR_CELL_W    = 5;
    localparam int unsigned HDR_RSVD_BIT  = 9;
    localparam int unsigned HDR_FOFB_W    = 9;
    localparam int unsigned FOFB_PREFIX_W = 4;

    typedef logic [1:0] status_code_t;

    localparam status_code_t STATUS_OK         = 2'd0;
    localparam status_code_t STATUS_DATA       = 2'd1;
    localparam status_code_t STATUS_FRAMING    = 2'd2;
    localparam status_code_t STATUS_INCOMPLETE = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StX,
        StY,
        StS,
        StResync
    } link_state_t;

    function automatic logic [HDR_FOFB_W-1:0] fofb_index(
        input logic [FOFB_PREFIX_W-1:0] prefix,
        input logic [IDX_W-1:0]         idx
    );
        return {prefix, idx};
    endfunction

    // Framing outranks data errors, which outrank an incomplete session.
    function automatic status_code_t report_code(
        input logic framing,
        input logic data,
        input logic incomplete
    );
        if (framing) return STATUS_FRAMING;
        if (data) return STATUS_DATA;
        if (incomplete) return STATUS_INCOMPLETE;
        return STATUS_OK;
    endfunction

endpackage

// File: rtl/bpm_test_word_check.sv
// Combinational expected-word generator and comparator for one test-link beat.
module bpm_test_word_check
    import bpm_test_link_pkg::*;
#(
    parameter int unsigned CELL_INDEX       = 12,
    parameter int unsigned BPM_GLOBAL_INDEX = 2
) (
    input  link_state_t      i_state,
    input  logic [IDX_W-1:0] i_index,
    input  logic [31:0]      i_data,
    output logic             o_match
);

    localparam logic [HDR_CELL_W-1:0]    CELL   = HDR_CELL_W'(CELL_INDEX);
    localparam logic [FOFB_PREFIX_W-1:0] PREFIX = FOFB_PREFIX_W'(BPM_GLOBAL_INDEX);

    logic [15:0] w_idx16;
    logic [31:0] w_expect;

    assign w_idx16 = {11'b0, i_index};

    always_comb begin
        w_expect = '0;
        o_match  = 1'b0;
        case (i_state)
            StHdr: begin
                w_expect = {MAGIC_HDR, 1'b1, CELL, 1'b0, fofb_index(PREFIX, i_index)};
                o_match  = (i_data == w_expect);
            end
            StX: begin
                w_expect = {MAGIC_X, w_idx16};
                o_match  = (i_data == w_expect);
            end
            StY: begin
                w_expect = {MAGIC_Y, w_idx16};
                o_match  = (i_data == w_expect);
            end
            // Upper half of the sum word is the cycle tag, checked by the parent.
            StS: begin
                w_expect = {16'h0000, w_idx16};
                o_match  = (i_data[15:0] == w_expect[15:0]);
            end
            default: o_match = 1'b0;
        endcase
    end

endmodule

// File: rtl/bpm_test_link_checker.sv
// BPM test-link stream checker: packet parsing, per-session status reports, counters.
// Optional BPM_TEST_CHECK_CYCLE_EN adds cycle-tag tracking on the sum word's upper half.
module bpm_test_link_checker
    import bpm_test_link_pkg::*;
#(
    parameter int unsigned BPM_COUNT        = 16,
    parameter int unsigned CELL_INDEX       = 12,
    parameter int unsigned BPM_GLOBAL_INDEX = 2
) (
    input  logic        auroraUserClk,
    input  logic        auroraReset,
    input  logic        auroraFAstrobe,
    input  logic [31:0] BPM_TEST_AXI_STREAM_RX_tdata,
    input  logic        BPM_TEST_AXI_STREAM_RX_tvalid,
    input  logic        BPM_TEST_AXI_STREAM_RX_tlast,
    output logic        BPM_TEST_AXI_STREAM_RX_tready,
    output logic        TESTstatusStrobe,
    output logic [1:0]  TESTstatusCode,
    output logic [15:0] packetCount,
    output logic [15:0] errorCount
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPM_COUNT - 1);

    link_state_t      r_state;
    logic [IDX_W-1:0] r_index;
    logic             r_tready;
    logic             r_strobe;
    status_code_t     r_code;
    logic [15:0]      r_pkt_cnt;
    logic [15:0]      r_err_cnt;
    logic             r_pkt_bad;
    logic             r_sess_data;
    logic             r_sess_framing;
    logic             r_stray;

    logic w_accept;
    logic w_tlast;
    logic w_match;
    logic w_cycle_ok;
    logic w_final;
    logic w_pkt_bad;
    logic w_err_inc;
    logic w_pkt_inc;

    assign w_accept  = BPM_TEST_AXI_STREAM_RX_tvalid && r_tready;
    assign w_tlast   = BPM_TEST_AXI_STREAM_RX_tlast;
    assign w_final   = (r_index == LAST_IDX);
    assign w_pkt_bad = r_pkt_bad || !w_match || !w_cycle_ok;

    bpm_test_word_check #(
        .CELL_INDEX       (CELL_INDEX),
        .BPM_GLOBAL_INDEX (BPM_GLOBAL_INDEX)
    ) u_word_check (
        .i_state (r_state),
        .i_index (r_index),
        .i_data  (BPM_TEST_AXI_STREAM_RX_tdata),
        .o_match (w_match)
    );

`ifdef BPM_TEST_CHECK_CYCLE_EN
    logic [15:0] r_cycle_ref;
    logic [15:0] r_cycle_prev;
    logic        r_cycle_seen;
    logic        r_prev_valid;
    logic [15:0] w_cycle_hi;
    logic        w_s_framed;

    assign w_cycle_hi = BPM_TEST_AXI_STREAM_RX_tdata[31:16];
    assign w_s_framed = w_accept && !auroraFAstrobe && (r_state == StS) && w_tlast;
    assign w_cycle_ok = r_cycle_seen ? (w_cycle_hi == r_cycle_ref)
                                     : (!r_prev_valid || (w_cycle_hi == r_cycle_prev + 16'd1));

    // First framed sum word of a session sets the tag; it rolls into r_cycle_prev at session end.
    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            r_cycle_ref  <= '0;
            r_cycle_prev <= '0;
            r_cycle_seen <= 1'b0;
            r_prev_valid <= 1'b0;
        end else if (auroraFAstrobe) begin
            if (r_cycle_seen) begin
                r_cycle_prev <= r_cycle_ref;
                r_prev_valid <= 1'b1;
            end
            r_cycle_seen <= 1'b0;
        end else if (w_s_framed) begin
            if (w_final) begin
                r_cycle_prev <= r_cycle_seen ? r_cycle_ref : w_cycle_hi;
                r_prev_valid <= 1'b1;
                r_cycle_seen <= 1'b0;
            end else if (!r_cycle_seen) begin
                r_cycle_ref  <= w_cycle_hi;
                r_cycle_seen <= 1'b1;
            end
        end
    end
`else
    assign w_cycle_ok = 1'b1;
`endif

    always_comb begin
        w_err_inc = 1'b0;
        w_pkt_inc = 1'b0;
        if (w_accept && !auroraFAstrobe) begin
            case (r_state)
                StIdle:          w_err_inc = 1'b1;
                StHdr, StX, StY: w_err_inc = w_tlast;
                StS: begin
                    if (!w_tlast || w_pkt_bad) begin
                        w_err_inc = 1'b1;
                    end else begin
                        w_pkt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            r_state        <= StIdle;
            r_index        <= '0;
            r_tready       <= 1'b0;
            r_strobe       <= 1'b0;
            r_code         <= STATUS_OK;
            r_pkt_cnt      <= '0;
            r_err_cnt      <= '0;
            r_pkt_bad      <= 1'b0;
            r_sess_data    <= 1'b0;
            r_sess_framing <= 1'b0;
            r_stray        <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            r_strobe <= 1'b0;
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
            if (w_pkt_inc && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;

            if (auroraFAstrobe) begin
                // Any open session is incomplete here; a completed one is already in StIdle.
                if (r_state != StIdle) begin
                    r_strobe <= 1'b1;
                    r_code   <= report_code(r_sess_framing || r_stray, r_sess_data, 1'b1);
                    r_stray  <= 1'b0;
                end
                r_sess_data    <= 1'b0;
                r_sess_framing <= 1'b0;
                r_pkt_bad      <= 1'b0;
                r_index        <= '0;
                r_state        <= StHdr;
            end else if (w_accept) begin
                case (r_state)
                    StIdle: r_stray <= 1'b1;
                    StHdr: begin
                        if (w_tlast) begin
                            r_sess_framing <= 1'b1;
                        end else begin
                            r_pkt_bad <= !w_match;
                            r_state   <= StX;
                        end
                    end
                    StX, StY: begin
                        if (w_tlast) begin
                            r_sess_framing <= 1'b1;
                            r_state        <= StHdr;
                        end else begin
                            r_pkt_bad <= r_pkt_bad || !w_match;
                            r_state   <= (r_state == StX) ? StY : StS;
                        end
                    end
                    StS: begin
                        if (!w_tlast) begin
                            r_sess_framing <= 1'b1;
                            r_state        <= StResync;
                        end else begin
                            if (w_pkt_bad) r_sess_data <= 1'b1;
                            if (w_final) begin
                                r_strobe <= 1'b1;
                                r_code   <= report_code(r_sess_framing || r_stray,
                                                        r_sess_data || w_pkt_bad, 1'b0);
                                r_stray  <= 1'b0;
                                r_state  <= StIdle;
                            end else begin
                                r_index <= r_index + 1'b1;
                                r_state <= StHdr;
                            end
                        end
                    end
                    StResync: begin
                        if (w_tlast) r_state <= StHdr;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign BPM_TEST_AXI_STREAM_RX_tready = r_tready;
    assign TESTstatusStrobe              = r_strobe;
    assign TESTstatusCode                = r_code;
    assign packetCount                   = r_pkt_cnt;
    assign errorCount                    = r_err_cnt;

endmodule

// File: tb/tb_bpm_test_link_checker.sv
// Self-checking bench for bpm_test_link_checker: session table plus hand-written corner cases.
module tb_bpm_test_link_checker;

    localparam int          N    = 16;
    localparam logic [4:0]  CELL = 5'd12;
    localparam logic [3:0]  PFX  = 4'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fa;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        sstb;
    logic [1:0]  scode;
    logic [15:0] pcnt;
    logic [15:0] ecnt;

    bpm_test_link_checker #(
        .BPM_COUNT        (N),
        .CELL_INDEX       (12),
        .BPM_GLOBAL_INDEX (2)
    ) dut (
        .auroraUserClk                 (clk),
        .auroraReset                   (rst),
        .auroraFAstrobe                (fa),
        .BPM_TEST_AXI_STREAM_RX_tdata  (tdata),
        .BPM_TEST_AXI_STREAM_RX_tvalid (tvalid),
        .BPM_TEST_AXI_STREAM_RX_tlast  (tlast),
        .BPM_TEST_AXI_STREAM_RX_tready (tready),
        .TESTstatusStrobe              (sstb),
        .TESTstatusCode                (scode),
        .packetCount                   (pcnt),
        .errorCount                    (ecnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } rep_t;
    rep_t q[$];
    rep_t m_e;

    typedef struct {
        int         bad_pkt;
        int         fault;
        logic [1:0] code;
        int         d_pkt;
        int         d_err;
    } vec_t;
    vec_t vecs[6];

    logic [15:0] hi;
    int          exp_pkt;
    int          exp_err;
    int          acc_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each report strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && sstb) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_report: code %0d at cycle %0d, none expected", scode, cyc);
            end else begin
                m_e = q.pop_front();
                check("report_code", {30'b0, scode}, {30'b0, m_e.code});
                check("report_cycle", cyc, m_e.cyc);
            end
        end
    end

    function automatic logic [31:0] hdr_w(input int i);
        return {16'hA5BE, 1'b1, CELL, 1'b0, PFX, 5'(i)};
    endfunction
    function automatic logic [31:0] x_w(input int i);
        return {16'hCAFE, 11'b0, 5'(i)};
    endfunction
    function automatic logic [31:0] y_w(input int i);
        return {16'hBEEF, 11'b0, 5'(i)};
    endfunction
    function automatic logic [31:0] s_w(input int i, input logic [15:0] tag);
        return {tag, 11'b0, 5'(i)};
    endfunction

    task automatic beat(input logic [31:0] d, input logic l);
        tvalid  = 1'b1;
        tdata   = d;
        tlast   = l;
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic fa_pulse();
        fa = 1'b1;
        @(posedge clk); #1;
        fa = 1'b0;
    endtask

    // fault: 1 bad X, 2 tlast on Y + resend, 3 bad header, 4 S without tlast + resync + resend,
    // 5 bad S low half.
    task automatic send_pkt(input int i, input int fault);
        logic [31:0] h, x, s;
        h = hdr_w(i);
        x = x_w(i);
        s = s_w(i, hi);
        if (fault == 1) x = {16'hCAFE, 11'b0, 5'(i - 1)};
        if (fault == 3) h[10] = ~h[10];
        if (fault == 5) s[0] = ~s[0];
        if (fault == 2) begin
            beat(h, 1'b0); beat(x, 1'b0); beat(y_w(i), 1'b1);
        end
        if (fault == 4) begin
            beat(h, 1'b0); beat(x, 1'b0); beat(y_w(i), 1'b0); beat(s, 1'b0);
            beat(32'h1234_5678, 1'b1);
        end
        beat(h, 1'b0); beat(x, 1'b0); beat(y_w(i), 1'b0); beat(s, 1'b1);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_packetCount"}, {16'b0, pcnt}, exp_pkt);
        check({tag, "_errorCount"}, {16'b0, ecnt}, exp_err);
    endtask

    task automatic run_session(input vec_t v, input bit open);
        if (open) fa_pulse();
        for (int i = 0; i < N; i++) send_pkt(i, (i == v.bad_pkt) ? v.fault : 0);
        q.push_back('{acc_cyc, v.code});
        exp_pkt += v.d_pkt;
        exp_err += v.d_err;
        hi = hi + 16'd1;
        repeat (2) @(posedge clk);
        #1;
        check_counters("session");
        check("report_seen", q.size(), 0);
    endtask

    initial begin
        vec_t clean;
        vec_t cyc_v;
        vecs[0] = '{-1, 0, 2'd0, 16, 0};
        vecs[1] = '{ 5, 1, 2'd1, 15, 1};
        vecs[2] = '{ 3, 2, 2'd2, 16, 1};
        vecs[3] = '{ 7, 3, 2'd1, 15, 1};
        vecs[4] = '{15, 4, 2'd2, 16, 1};
        vecs[5] = '{ 0, 5, 2'd1, 15, 1};
        clean   = vecs[0];

        rst = 1'b1; fa = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        hi = 16'd0; exp_pkt = 0; exp_err = 0; acc_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tready", {31'b0, tready}, 0);
        check("reset_strobe", {31'b0, sstb}, 0);
        check("reset_code", {30'b0, scode}, 0);
        check_counters("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("tready_after_reset", {31'b0, tready}, 1);

        for (int k = 0; k < 6; k++) run_session(vecs[k], 1'b1);

        // Code register holds between reports.
        repeat (3) @(posedge clk);
        #1;
        check("code_hold", {30'b0, scode}, 1);

        // Strobe after 10 clean packets: incomplete, then the new session starts at index 0.
        fa_pulse();
        for (int i = 0; i < 10; i++) send_pkt(i, 0);
        exp_pkt += 10;
        hi = hi + 16'd1;
        fa = 1'b1;
        q.push_back('{cyc + 1, 2'd3});
        @(posedge clk); #1;
        fa = 1'b0;
        run_session(clean, 1'b0);

        // Two stray beats after completion, then a clean session reports framing.
        beat(x_w(0), 1'b0);
        beat(y_w(0), 1'b1);
        exp_err += 2;
        @(posedge clk); #1;
        check_counters("stray");
        run_session('{-1, 0, 2'd2, 16, 0}, 1'b1);

        // Strobe coinciding with the final S beat: beat dropped, incomplete, new session.
        fa_pulse();
        for (int i = 0; i < N - 1; i++) send_pkt(i, 0);
        beat(hdr_w(N - 1), 1'b0);
        beat(x_w(N - 1), 1'b0);
        beat(y_w(N - 1), 1'b0);
        fa = 1'b1;
        beat(s_w(N - 1, hi), 1'b1);
        fa = 1'b0;
        q.push_back('{acc_cyc, 2'd3});
        exp_pkt += N - 1;
        hi = hi + 16'd1;
        run_session(clean, 1'b0);

        // Reset mid-session: no report, everything back to reset values.
        fa_pulse();
        for (int i = 0; i < 5; i++) send_pkt(i, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_pkt = 0;
        exp_err = 0;
        check("midreset_tready", {31'b0, tready}, 0);
        check_counters("midreset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Cycle tags 7 then 9 across sessions.
        hi = 16'd7;
        run_session(clean, 1'b1);
        hi = 16'd9;
`ifdef BPM_TEST_CHECK_CYCLE_EN
        cyc_v = '{-1, 0, 2'd1, 15, 1};
`else
        cyc_v = clean;
`endif
        run_session(cyc_v, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
